// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the phase-3 CPU control sequencer:
// opcodes, sequencer states, the datapath strobe bundle and ALU selects.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_BR   = 5'b10010,
    OP_JR   = 5'b10100,
    OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } opcode_e;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_e;

  typedef struct packed {
    logic PCout;
    logic PCin;
    logic IncPC;
    logic MARin;
    logic MDRin;
    logic MDRout;
    logic MDRRead;
    logic RAMread;
    logic RAMwrite;
    logic IRin;
    logic Yin;
    logic Zin;
    logic Zlowout;
    logic Zhighout;
    logic Cout;
    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin_in;
    logic Rout_in;
    logic BAout;
    logic CONin;
    logic HIin;
    logic LOin;
    logic HIout;
    logic LOout;
    logic InPortout;
    logic OutPortIn;
  } ctrl_t;

  localparam logic [11:0] ALU_ADD = 12'h001;
  localparam logic [11:0] ALU_SUB = 12'h002;
  localparam logic [11:0] ALU_AND = 12'h004;
  localparam logic [11:0] ALU_OR  = 12'h008;

  function automatic logic is_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST,
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI,
      OP_BR, OP_JR, OP_NOP, OP_HALT:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // Final execute step; undefined opcodes end at T3 like nop.
  function automatic state_e last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:
        return S_T7;
      OP_BR:
        return S_T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI:
        return S_T5;
      default:
        return S_T3;
    endcase
  endfunction

  function automatic logic [11:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      default:         return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Sequencer <-> datapath bundle: IR and CON in,
// strobes, ALU select and run flag out.
interface control_unit_if;
  logic [31:0]         ir;
  logic                con_ff;
  cpu_ctrl_pkg::ctrl_t ctrl;
  logic [11:0]         ALUControl;
  logic                run;

  modport master (
    input  ir,
    input  con_ff,
    output ctrl,
    output ALUControl,
    output run
  );

  modport slave (
    output ir,
    output con_ff,
    input  ctrl,
    input  ALUControl,
    input  run
  );
endinterface

// File: rtl/control_decode.sv
// Strobe decoder: maps (state, opcode, con_ff)
// to the datapath strobe set and one-hot ALU select.
module control_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [4:0]  op,
  input  logic        con_ff,
  output ctrl_t       ctrl,
  output logic [11:0] alu
);

  logic is_ld, is_ldi, is_st;
  logic is_r, is_imm, is_br, is_jr;
  logic is_mem;

  assign is_ld  = (op == OP_LD);
  assign is_ldi = (op == OP_LDI);
  assign is_st  = (op == OP_ST);
  assign is_r   = (op == OP_ADD) || (op == OP_SUB) ||
                  (op == OP_AND) || (op == OP_OR);
  assign is_imm = (op == OP_ADDI) || (op == OP_ANDI) ||
                  (op == OP_ORI);
  assign is_br  = (op == OP_BR);
  assign is_jr  = (op == OP_JR);
  assign is_mem = is_ld || is_ldi || is_st;

  always_comb begin
    ctrl = '0;
    alu  = '0;
    unique case (state)
      S_T0: begin
        ctrl.PCout = 1'b1;
        ctrl.MARin = 1'b1;
        ctrl.IncPC = 1'b1;
        ctrl.Zin   = 1'b1;
        alu        = ALU_ADD;
      end
      S_T1: begin
        ctrl.Zlowout = 1'b1;
        ctrl.PCin    = 1'b1;
        ctrl.RAMread = 1'b1;
        ctrl.MDRRead = 1'b1;
        ctrl.MDRin   = 1'b1;
      end
      S_T2: begin
        ctrl.MDRout = 1'b1;
        ctrl.IRin   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_mem: begin
            ctrl.Grb   = 1'b1;
            ctrl.BAout = 1'b1;
            ctrl.Yin   = 1'b1;
          end
          (is_r || is_imm): begin
            ctrl.Grb     = 1'b1;
            ctrl.Rout_in = 1'b1;
            ctrl.Yin     = 1'b1;
          end
          is_br: begin
            ctrl.Gra     = 1'b1;
            ctrl.Rout_in = 1'b1;
            ctrl.CONin   = 1'b1;
          end
          is_jr: begin
            ctrl.Gra     = 1'b1;
            ctrl.Rout_in = 1'b1;
            ctrl.PCin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          is_mem: begin
            ctrl.Cout = 1'b1;
            ctrl.Zin  = 1'b1;
            alu       = ALU_ADD;
          end
          is_r: begin
            ctrl.Grc     = 1'b1;
            ctrl.Rout_in = 1'b1;
            ctrl.Zin     = 1'b1;
            alu          = alu_sel(op);
          end
          is_imm: begin
            ctrl.Cout = 1'b1;
            ctrl.Zin  = 1'b1;
            alu       = alu_sel(op);
          end
          is_br: begin
            ctrl.PCout = 1'b1;
            ctrl.Yin   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          (is_ld || is_st): begin
            ctrl.Zlowout = 1'b1;
            ctrl.MARin   = 1'b1;
          end
          (is_ldi || is_r || is_imm): begin
            ctrl.Zlowout = 1'b1;
            ctrl.Gra     = 1'b1;
            ctrl.Rin_in  = 1'b1;
          end
          is_br: begin
            ctrl.Cout = 1'b1;
            ctrl.Zin  = 1'b1;
            alu       = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          is_ld: begin
            ctrl.RAMread = 1'b1;
            ctrl.MDRRead = 1'b1;
            ctrl.MDRin   = 1'b1;
          end
          is_st: begin
            ctrl.Gra     = 1'b1;
            ctrl.Rout_in = 1'b1;
            ctrl.MDRin   = 1'b1;
          end
          is_br: begin
            ctrl.Zlowout = con_ff;
            ctrl.PCin    = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          is_ld: begin
            ctrl.MDRout = 1'b1;
            ctrl.Gra    = 1'b1;
            ctrl.Rin_in = 1'b1;
          end
          is_st: ctrl.RAMwrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: state register and next-state
// logic; strobes come from control_decode.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic clk,
  input  logic clr,
  control_unit_if.master cu
);

  state_e     state;
  logic [4:0] op;
  logic       stop;
  state_e     last;
  logic       unused_ir;

  assign op        = cu.ir[31:27];
  assign unused_ir = ^cu.ir[26:0];
  assign last      = last_step(op);
  assign stop      = (op == OP_HALT) ||
                     (HALT_ON_UNDEF && !is_defined(op));

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET: state <= S_T0;
        S_HALT:  state <= S_HALT;
        S_T3: begin
          if (stop)
            state <= S_HALT;
          else if (last == S_T3)
            state <= S_T0;
          else
            state <= S_T4;
        end
        default: begin
          if (state == last || state == S_T7)
            state <= S_T0;
          else
            state <= state_e'(state + 4'd1);
        end
      endcase
    end
  end

  assign cu.run = (state != S_RESET) &&
                  (state != S_HALT);

  control_decode u_decode (
    .state  (state),
    .op     (op),
    .con_ff (cu.con_ff),
    .ctrl   (cu.ctrl),
    .alu    (cu.ALUControl)
  );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction table
// plus random programs against a step-counting model.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  localparam int M_RESET = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        con;
    int          len;
    int          spot;
    ctrl_t       c;
    logic [11:0] a;
  } vec_t;

  logic clk;
  logic clr;
  control_unit_if cu_if ();

  control_unit #(.HALT_ON_UNDEF(1'b0)) dut (
    .clk (clk),
    .clr (clr),
    .cu  (cu_if.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;
  int m_mode = M_RESET;
  int m_k = 0;
  logic [31:0] cur_ir = '0;
  int ramw_seen = 0;

  function automatic int instr_len(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00010: return 8;
      5'b10010:           return 7;
      5'b00001, 5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b01100, 5'b01101, 5'b01110:
        return 6;
      default:            return 4;
    endcase
  endfunction

  function automatic logic [11:0] alu_of(input logic [4:0] op);
    logic [11:0] one;
    one = 12'h001;
    case (op)
      5'b00011, 5'b01100: return one;
      5'b00100:           return one << 1;
      5'b00101, 5'b01101: return one << 2;
      5'b00110, 5'b01110: return one << 3;
      default:            return 12'h000;
    endcase
  endfunction

  // Expected strobes for step k of an instruction.
  function automatic void exp_step(
    input  logic [4:0]  op,
    input  int          k,
    input  logic        con,
    output ctrl_t       c,
    output logic [11:0] a
  );
    bit ld, ldi, st, rr, im, br, jr;
    ld  = (op == 5'b00000);
    ldi = (op == 5'b00001);
    st  = (op == 5'b00010);
    rr  = (op >= 5'b00011) && (op <= 5'b00110);
    im  = (op >= 5'b01100) && (op <= 5'b01110);
    br  = (op == 5'b10010);
    jr  = (op == 5'b10100);
    c = '0;
    a = '0;
    case (k)
      0: begin
        c.PCout = 1; c.MARin = 1; c.IncPC = 1;
        c.Zin = 1; a = 12'h001;
      end
      1: begin
        c.Zlowout = 1; c.PCin = 1; c.RAMread = 1;
        c.MDRRead = 1; c.MDRin = 1;
      end
      2: begin
        c.MDRout = 1; c.IRin = 1;
      end
      3: begin
        if (ld || ldi || st) begin
          c.Grb = 1; c.BAout = 1; c.Yin = 1;
        end else if (rr || im) begin
          c.Grb = 1; c.Rout_in = 1; c.Yin = 1;
        end else if (br) begin
          c.Gra = 1; c.Rout_in = 1; c.CONin = 1;
        end else if (jr) begin
          c.Gra = 1; c.Rout_in = 1; c.PCin = 1;
        end
      end
      4: begin
        if (ld || ldi || st) begin
          c.Cout = 1; c.Zin = 1; a = 12'h001;
        end else if (rr) begin
          c.Grc = 1; c.Rout_in = 1; c.Zin = 1;
          a = alu_of(op);
        end else if (im) begin
          c.Cout = 1; c.Zin = 1; a = alu_of(op);
        end else if (br) begin
          c.PCout = 1; c.Yin = 1;
        end
      end
      5: begin
        if (ld || st) begin
          c.Zlowout = 1; c.MARin = 1;
        end else if (ldi || rr || im) begin
          c.Zlowout = 1; c.Gra = 1; c.Rin_in = 1;
        end else if (br) begin
          c.Cout = 1; c.Zin = 1; a = 12'h001;
        end
      end
      6: begin
        if (ld) begin
          c.RAMread = 1; c.MDRRead = 1; c.MDRin = 1;
        end else if (st) begin
          c.Gra = 1; c.Rout_in = 1; c.MDRin = 1;
        end else if (br && con) begin
          c.Zlowout = 1; c.PCin = 1;
        end
      end
      7: begin
        if (ld) begin
          c.MDRout = 1; c.Gra = 1; c.Rin_in = 1;
        end else if (st) begin
          c.RAMwrite = 1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model,
  // then advance the model across the edge.
  task automatic tick(
    input  logic        c_clr,
    input  logic [31:0] c_ir,
    input  logic        c_con,
    output ctrl_t       oc,
    output logic [11:0] oa,
    output logic        orun
  );
    ctrl_t ec;
    logic [11:0] ea;
    logic er;
    int nmode, nk;
    clr = c_clr;
    cu_if.ir = c_ir;
    cu_if.con_ff = c_con;
    cur_ir = c_ir;
    #1;
    oc = cu_if.ctrl;
    oa = cu_if.ALUControl;
    orun = cu_if.run;
    if (oc.RAMwrite === 1'b1) ramw_seen++;
    if (m_mode == M_RUN) begin
      exp_step(c_ir[31:27], m_k, c_con, ec, ea);
      er = 1'b1;
    end else begin
      ec = '0;
      ea = '0;
      er = 1'b0;
    end
    nvec++;
    if (oc !== ec || oa !== ea || orun !== er) begin
      nerr++;
      $display("FAIL step mode=%0d k=%0d op=%b: ctrl=%h alu=%h run=%b, want ctrl=%h alu=%h run=%b",
               m_mode, m_k, c_ir[31:27], oc, oa, orun, ec, ea, er);
    end
    nmode = m_mode;
    nk = m_k;
    if (c_clr) begin
      nmode = M_RESET;
      nk = 0;
    end else if (m_mode == M_RESET) begin
      nmode = M_RUN;
      nk = 0;
    end else if (m_mode == M_RUN) begin
      if (m_k == instr_len(c_ir[31:27]) - 1) begin
        nmode = (c_ir[31:27] == 5'b11011) ? M_HALT : M_RUN;
        nk = 0;
      end else begin
        nk = m_k + 1;
      end
    end
    @(posedge clk);
    #1;
    m_mode = nmode;
    m_k = nk;
  endtask

  task automatic run_instr(input vec_t v);
    ctrl_t c, sc;
    logic [11:0] a, sa;
    logic r;
    logic [26:0] lo;
    logic [31:0] irv;
    ctrl_t t0c;
    lo = 27'($urandom);
    sc = '0;
    sa = '0;
    for (int k = 0; k < v.len; k++) begin
      if (k == 0)
        irv = cur_ir;
      else if (k == 1)
        irv = $urandom;
      else
        irv = {v.op, lo};
      tick(1'b0, irv, v.con, c, a, r);
      if (k == v.spot) begin
        sc = c;
        sa = a;
      end
    end
    chk({v.name, " spot"}, {24'h0, sc, sa}, {24'h0, v.c, v.a});
    t0c = '0;
    t0c.PCout = 1; t0c.MARin = 1;
    t0c.IncPC = 1; t0c.Zin = 1;
    chk({v.name, " len"},
        {24'h0, cu_if.ctrl, cu_if.ALUControl},
        {24'h0, t0c, 12'h001});
  endtask

  function automatic logic [4:0] pick_op();
    logic [4:0] ops [14];
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b00110, 5'b01100,
            5'b01101, 5'b01110, 5'b10010, 5'b10100,
            5'b11010, 5'b11011};
    if ($urandom_range(0, 3) == 0)
      return 5'($urandom);
    return ops[$urandom_range(0, 13)];
  endfunction

  vec_t tbl[$];

  initial begin
    ctrl_t c, oc;
    logic [11:0] oa;
    logic orun;
    int runs;
    logic [31:0] irv;
    logic cl;

    clr = 1'b1;
    cu_if.ir = '0;
    cu_if.con_ff = 1'b0;

    c = '0; c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1;
    tbl.push_back('{"t0", 5'b11010, 1'b0, 4, 0, c, 12'h001});
    c = '0; c.RAMread = 1; c.MDRRead = 1; c.MDRin = 1;
    tbl.push_back('{"ld_t6", 5'b00000, 1'b0, 8, 6, c, 12'h000});
    c = '0; c.MDRout = 1; c.Gra = 1; c.Rin_in = 1;
    tbl.push_back('{"ld_t7", 5'b00000, 1'b0, 8, 7, c, 12'h000});
    c = '0; c.Grc = 1; c.Rout_in = 1; c.Zin = 1;
    tbl.push_back('{"sub_t4", 5'b00100, 1'b0, 6, 4, c, 12'h002});
    c = '0; c.Zlowout = 1; c.Gra = 1; c.Rin_in = 1;
    tbl.push_back('{"sub_t5", 5'b00100, 1'b0, 6, 5, c, 12'h000});
    c = '0;
    tbl.push_back('{"br0_t6", 5'b10010, 1'b0, 7, 6, c, 12'h000});
    c = '0; c.Zlowout = 1; c.PCin = 1;
    tbl.push_back('{"br1_t6", 5'b10010, 1'b1, 7, 6, c, 12'h000});
    c = '0; c.Zlowout = 1; c.Gra = 1; c.Rin_in = 1;
    tbl.push_back('{"ldi_t5", 5'b00001, 1'b0, 6, 5, c, 12'h000});
    c = '0; c.Gra = 1; c.Rout_in = 1; c.MDRin = 1;
    tbl.push_back('{"st_t6", 5'b00010, 1'b0, 8, 6, c, 12'h000});
    c = '0; c.RAMwrite = 1;
    tbl.push_back('{"st_t7", 5'b00010, 1'b0, 8, 7, c, 12'h000});
    c = '0; c.Grc = 1; c.Rout_in = 1; c.Zin = 1;
    tbl.push_back('{"and_t4", 5'b00101, 1'b0, 6, 4, c, 12'h004});
    c = '0; c.Cout = 1; c.Zin = 1;
    tbl.push_back('{"ori_t4", 5'b01110, 1'b0, 6, 4, c, 12'h008});
    c = '0; c.Cout = 1; c.Zin = 1;
    tbl.push_back('{"addi_t4", 5'b01100, 1'b0, 6, 4, c, 12'h001});
    c = '0; c.Gra = 1; c.Rout_in = 1; c.PCin = 1;
    tbl.push_back('{"jr_t3", 5'b10100, 1'b0, 4, 3, c, 12'h000});
    c = '0;
    tbl.push_back('{"undef_t3", 5'b11111, 1'b1, 4, 3, c, 12'h000});

    // clr held across two edges, then released
    @(posedge clk);
    #1;
    m_mode = M_RESET;
    tick(1'b1, '0, 1'b0, oc, oa, orun);
    chk("reset run", {63'h0, orun}, 64'h0);
    tick(1'b0, '0, 1'b0, oc, oa, orun);
    chk("reset ctrl", {24'h0, oc, oa}, 64'h0);

    foreach (tbl[i]) run_instr(tbl[i]);

    // halt: run drops after T3 and stays low
    for (int k = 0; k < 4; k++) begin
      irv = (k == 1) ? $urandom : {5'b11011, 27'h0};
      tick(1'b0, irv, 1'b0, oc, oa, orun);
    end
    runs = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, cur_ir, 1'b1, oc, oa, orun);
      if (orun !== 1'b0) runs++;
    end
    chk("halt run held", 64'(runs), 64'h0);
    tick(1'b1, cur_ir, 1'b0, oc, oa, orun);
    tick(1'b0, cur_ir, 1'b0, oc, oa, orun);
    chk("halt clr reset", {24'h0, oc, oa}, 64'h0);

    // clr during st T6: no RAMwrite, RESET next
    ramw_seen = 0;
    for (int k = 0; k < 7; k++) begin
      irv = (k == 1) ? $urandom : {5'b00010, 27'h85};
      tick(k == 6, irv, 1'b0, oc, oa, orun);
    end
    tick(1'b0, cur_ir, 1'b0, oc, oa, orun);
    chk("st abort reset", {23'h0, orun, oc, oa}, 64'h0);
    chk("st abort ramwrite", 64'(ramw_seen), 64'h0);

    // random programs
    for (int n = 0; n < 1500; n++) begin
      if (m_mode == M_HALT)
        cl = ($urandom_range(0, 4) == 0);
      else
        cl = ($urandom_range(0, 59) == 0);
      if (m_mode == M_RUN && m_k == 1)
        irv = $urandom;
      else if (m_mode == M_RUN && m_k == 2)
        irv = {pick_op(), 27'($urandom)};
      else
        irv = cur_ir;
      tick(cl, irv, 1'($urandom_range(0, 1)), oc, oa, orun);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
